mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameter NB_DATA, default 32: data word width.
REQ-002 SHALL take ADDRWIDTH from the shared parameters header: dmem word-address width.
REQ-003 SHALL have ports i_clk (in, 1, clock) and i_reset (in, 1): one clock; reset is synchronous and active-low.
REQ-004 SHALL have i_valid (in, 1): an EX/MEM memory request is present.
REQ-005 SHALL have i_mem_read and i_mem_write (in, 1 each): load or store request.
REQ-006 SHALL have i_width (in, 2): 00 byte, 01 half, 10 word, 11 reserved (treated as word).
REQ-007 SHALL have i_unsigned (in, 1): zero-extend loads when 1, sign-extend when 0.
REQ-008 SHALL have i_addr (in, 32, byte address) and i_wdata (in, NB_DATA, store data right-aligned).
REQ-009 SHALL have o_dmem_enable, o_dmem_read and o_dmem_write (out, 1 each), o_dmem_addr (out, ADDRWIDTH), o_dmem_wdata (out, NB_DATA) and i_dmem_rdata (in, NB_DATA): dmem side.
REQ-010 SHALL have o_stall (out, 1): freeze upstream pipeline.
REQ-011 SHALL have o_rdata (out, NB_DATA): formatted load data.
REQ-012 SHALL have o_rdata_valid (out, 1): one-cycle load-complete pulse.
REQ-013 SHALL have o_misaligned (out, 1): misaligned-access pulse.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, RMW_READ, WRITE; all dmem outputs registered.
REQ-015 SHALL accept a request only in IDLE when i_valid=1 and at least one of read/write is set; otherwise stay in IDLE.
REQ-016 SHALL give write priority when read and write are both set; the read is discarded.
REQ-017 SHALL drive o_dmem_addr = i_addr[ADDRWIDTH+1:2]; upper address bits are ignored.
REQ-018 SHALL use little-endian byte lanes: byte n occupies bits 8n+7:8n.
REQ-019 SHALL handle a load accepted at edge k as follows: go to LOAD with enable=1, read=1; at edge k+1 capture i_dmem_rdata (dmem updates on negedge); extract and extend it into o_rdata; pulse o_rdata_valid for one cycle; return to IDLE.
REQ-020 SHALL handle a word store accepted at edge k as follows: go to WRITE with enable=1, write=1, wdata=i_wdata; dmem commits at edge k+1; return to IDLE.
REQ-021 SHALL handle byte and half stores by read-modify-write: accept at k, go to RMW_READ (read=1); at k+1 merge the addressed lane(s) from the latched i_wdata into the read word and go to WRITE; commit at k+2; return to IDLE.
REQ-022 SHALL assert o_stall whenever state != IDLE: 1 cycle for loads and word stores, 2 cycles for sub-word stores.
REQ-023 SHALL latch request fields at acceptance; inputs are ignored while stalled.
REQ-024 SHALL hold o_dmem_read=0 and o_dmem_write=0 in every state other than those named above; o_dmem_enable=0 in IDLE.
REQ-025 SHALL hold o_rdata at its last value between loads.
REQ-026 SHALL treat a request as misaligned when it is a half access with addr[0]=1, or a word access with addr[1:0]!=0.

Reset
REQ-027 SHALL, while i_reset=0 at a rising edge: set state to IDLE; clear all outputs to 0, including o_rdata; drop any in-flight transaction, so a partially completed RMW is not written.
REQ-028 SHALL accept a new request on the first edge after i_reset returns to 1.

Configuration
REQ-029 SHALL, with macro MEM_ALIGN_CHECK_EN defined, reject misaligned requests: no dmem access, no stall, o_misaligned=1 for one cycle after the accepting edge, state stays IDLE.
REQ-030 SHALL, without MEM_ALIGN_CHECK_EN, force the low alignment bits to zero and perform the access normally; o_misaligned is tied to 0.

Structure
REQ-031 SHALL place width codes (BYTE/HALF/WORD) and FSM state encodings in the shared parameters header, next to ADDRWIDTH.
REQ-032 SHALL place lane extraction and sign/zero extension in combinational sub-module mem_load_format, instantiated once.

Verification
REQ-033 SHALL cover word store then load: SW 0xDEADBEEF at byte addr 0x10; LW from 0x10. Required: dmem word 4 = 0xDEADBEEF; o_rdata=0xDEADBEEF with o_rdata_valid 1 cycle; o_stall 1 cycle for each access.
REQ-034 SHALL cover byte loads: word 4 = 0x80FF7F01. LB 0x13 gives 0xFFFFFF80; LBU 0x13 gives 0x00000080; LB 0x10 gives 0x00000001.
REQ-035 SHALL cover RMW store: word 4 = 0x11223344; SH 0xABCD to 0x12. Required: word 4 = 0xABCD3344; o_stall high exactly 2 cycles; read then write seen on the dmem ports.
REQ-036 SHALL cover misaligned access: LW at 0x11. With MEM_ALIGN_CHECK_EN: o_misaligned pulses once, o_dmem_enable stays 0. Without the macro: o_rdata = word 4.
REQ-037 SHALL cover reset mid-operation: i_reset=0 at the edge after an SB acceptance. Required: no dmem write; state IDLE; all outputs 0 next cycle.
REQ-038 SHALL cover simultaneous read and write: i_mem_read=i_mem_write=1, SW 0x5 at 0x0. Required: write occurs and o_rdata_valid stays 0.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// ============================================================================
// Module      : mem_access_ctrl_pkg
// Description : Shared parameters for the data-memory access controller:
//               dmem word-address width, access-width codes, FSM encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_access_ctrl_pkg;

    localparam int ADDRWIDTH = 10;

    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD     = 2'd1,
        ST_RMW_READ = 2'd2,
        ST_WRITE    = 2'd3
    } state_t;

    // The reserved width code behaves exactly like a word access.
    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] offset);
        if (width == WIDTH_BYTE)
            return 1'b0;
        else if (width == WIDTH_HALF)
            return offset[0];
        else
            return (offset != 2'b00);
    endfunction

    function automatic logic [1:0] align_offset(input logic [1:0] width, input logic [1:0] offset);
        if (width == WIDTH_BYTE)
            return offset;
        else if (width == WIDTH_HALF)
            return {offset[1], 1'b0};
        else
            return 2'b00;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_access_ctrl_load_format.sv
// ============================================================================
// Module      : mem_load_format
// Description : Combinational load formatter: selects the addressed byte or
//               half-word lane and sign- or zero-extends it to NB_DATA bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_load_format
    import mem_access_ctrl_pkg::*;
#(
    parameter int NB_DATA = 32
) (
    input  logic [NB_DATA-1:0] i_word,
    input  logic [1:0]         i_offset,
    input  logic [1:0]         i_width,
    input  logic               i_unsigned,
    output logic [NB_DATA-1:0] o_data
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    // Shifting the addressed lane down to bit 0 serves both byte and half.
    assign w_half = 16'(i_word >> {i_offset, 3'b000});
    assign w_byte = w_half[7:0];

    always_comb begin
        o_data = i_word;
        case (i_width)
            WIDTH_BYTE: o_data = {{(NB_DATA-8){~i_unsigned & w_byte[7]}}, w_byte};
            WIDTH_HALF: o_data = {{(NB_DATA-16){~i_unsigned & w_half[15]}}, w_half};
            default:    o_data = i_word;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module      : mem_access_ctrl
// Description : EX/MEM data-memory access controller with sub-word stores by
//               read-modify-write. Optional macro MEM_ALIGN_CHECK_EN rejects
//               misaligned requests instead of force-aligning them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int NB_DATA = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_valid,
    input  logic                 i_mem_read,
    input  logic                 i_mem_write,
    input  logic [1:0]           i_width,
    input  logic                 i_unsigned,
    input  logic [31:0]          i_addr,
    input  logic [NB_DATA-1:0]   i_wdata,
    output logic                 o_dmem_enable,
    output logic                 o_dmem_read,
    output logic                 o_dmem_write,
    output logic [ADDRWIDTH-1:0] o_dmem_addr,
    output logic [NB_DATA-1:0]   o_dmem_wdata,
    input  logic [NB_DATA-1:0]   i_dmem_rdata,
    output logic                 o_stall,
    output logic [NB_DATA-1:0]   o_rdata,
    output logic                 o_rdata_valid,
    output logic                 o_misaligned
);

    state_t               r_state;
    logic [1:0]           r_width;
    logic [1:0]           r_offset;
    logic                 r_unsigned;
    logic [15:0]          r_sub_wdata;
    logic                 r_dmem_enable;
    logic                 r_dmem_read;
    logic                 r_dmem_write;
    logic [ADDRWIDTH-1:0] r_dmem_addr;
    logic [NB_DATA-1:0]   r_dmem_wdata;
    logic [NB_DATA-1:0]   r_rdata;
    logic                 r_rdata_valid;

    logic                 w_accept;
    logic                 w_reject;
    logic                 w_sub_word;
    logic [1:0]           w_offset;
    logic [NB_DATA-1:0]   w_load_data;
    logic [NB_DATA-1:0]   w_merged;
    logic                 w_unused_addr;

    assign w_unused_addr = ^i_addr[31:ADDRWIDTH+2];

    assign w_accept   = (r_state == ST_IDLE) && i_valid && (i_mem_read || i_mem_write);
    assign w_sub_word = (i_width == WIDTH_BYTE) || (i_width == WIDTH_HALF);

`ifdef MEM_ALIGN_CHECK_EN
    logic r_misaligned;
    assign w_reject     = is_misaligned(i_width, i_addr[1:0]);
    assign w_offset     = i_addr[1:0];
    assign o_misaligned = r_misaligned;
`else
    assign w_reject     = 1'b0;
    assign w_offset     = align_offset(i_width, i_addr[1:0]);
    assign o_misaligned = 1'b0;
`endif

    mem_load_format #(
        .NB_DATA    (NB_DATA)
    ) u_load_format (
        .i_word     (i_dmem_rdata),
        .i_offset   (r_offset),
        .i_width    (r_width),
        .i_unsigned (r_unsigned),
        .o_data     (w_load_data)
    );

    // Replace only the addressed lane(s) of the word read back from dmem.
    always_comb begin
        w_merged = i_dmem_rdata;
        for (int n = 0; n < NB_DATA/8; n++) begin
            if (n == int'(r_offset))
                w_merged[8*n +: 8] = r_sub_wdata[7:0];
            if ((r_width == WIDTH_HALF) && (n == int'(r_offset) + 1))
                w_merged[8*n +: 8] = r_sub_wdata[15:8];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state       <= ST_IDLE;
            r_width       <= 2'b00;
            r_offset      <= 2'b00;
            r_unsigned    <= 1'b0;
            r_sub_wdata   <= '0;
            r_dmem_enable <= 1'b0;
            r_dmem_read   <= 1'b0;
            r_dmem_write  <= 1'b0;
            r_dmem_addr   <= '0;
            r_dmem_wdata  <= '0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            r_misaligned  <= 1'b0;
`endif
        end else begin
            r_rdata_valid <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            r_misaligned  <= w_accept && w_reject;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && !w_reject) begin
                        r_width       <= i_width;
                        r_offset      <= w_offset;
                        r_unsigned    <= i_unsigned;
                        r_sub_wdata   <= i_wdata[15:0];
                        r_dmem_enable <= 1'b1;
                        r_dmem_addr   <= i_addr[ADDRWIDTH+1:2];
                        // A write wins when both read and write are requested.
                        if (!i_mem_write) begin
                            r_state     <= ST_LOAD;
                            r_dmem_read <= 1'b1;
                        end else if (w_sub_word) begin
                            r_state     <= ST_RMW_READ;
                            r_dmem_read <= 1'b1;
                        end else begin
                            r_state      <= ST_WRITE;
                            r_dmem_write <= 1'b1;
                            r_dmem_wdata <= i_wdata;
                        end
                    end
                end
                ST_LOAD: begin
                    r_rdata       <= w_load_data;
                    r_rdata_valid <= 1'b1;
                    r_dmem_enable <= 1'b0;
                    r_dmem_read   <= 1'b0;
                    r_state       <= ST_IDLE;
                end
                ST_RMW_READ: begin
                    r_dmem_read  <= 1'b0;
                    r_dmem_write <= 1'b1;
                    r_dmem_wdata <= w_merged;
                    r_state      <= ST_WRITE;
                end
                ST_WRITE: begin
                    r_dmem_enable <= 1'b0;
                    r_dmem_write  <= 1'b0;
                    r_state       <= ST_IDLE;
                end
                default: begin
                    r_dmem_enable <= 1'b0;
                    r_dmem_read   <= 1'b0;
                    r_dmem_write  <= 1'b0;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_dmem_enable = r_dmem_enable;
    assign o_dmem_read   = r_dmem_read;
    assign o_dmem_write  = r_dmem_write;
    assign o_dmem_addr   = r_dmem_addr;
    assign o_dmem_wdata  = r_dmem_wdata;
    assign o_stall       = (r_state != ST_IDLE);
    assign o_rdata       = r_rdata;
    assign o_rdata_valid = r_rdata_valid;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Directed self-checking bench for mem_access_ctrl with a
//               behavioural dmem (reads on negedge, writes on posedge).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;

    localparam int NB_DATA = 32;
    localparam int AW      = 10;

    logic               clk;
    logic               i_reset;
    logic               i_valid;
    logic               i_mem_read;
    logic               i_mem_write;
    logic [1:0]         i_width;
    logic               i_unsigned;
    logic [31:0]        i_addr;
    logic [NB_DATA-1:0] i_wdata;
    logic               o_dmem_enable;
    logic               o_dmem_read;
    logic               o_dmem_write;
    logic [AW-1:0]      o_dmem_addr;
    logic [NB_DATA-1:0] o_dmem_wdata;
    logic [NB_DATA-1:0] i_dmem_rdata;
    logic               o_stall;
    logic [NB_DATA-1:0] o_rdata;
    logic               o_rdata_valid;
    logic               o_misaligned;

    mem_access_ctrl #(.NB_DATA(NB_DATA)) dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_valid       (i_valid),
        .i_mem_read    (i_mem_read),
        .i_mem_write   (i_mem_write),
        .i_width       (i_width),
        .i_unsigned    (i_unsigned),
        .i_addr        (i_addr),
        .i_wdata       (i_wdata),
        .o_dmem_enable (o_dmem_enable),
        .o_dmem_read   (o_dmem_read),
        .o_dmem_write  (o_dmem_write),
        .o_dmem_addr   (o_dmem_addr),
        .o_dmem_wdata  (o_dmem_wdata),
        .i_dmem_rdata  (i_dmem_rdata),
        .o_stall       (o_stall),
        .o_rdata       (o_rdata),
        .o_rdata_valid (o_rdata_valid),
        .o_misaligned  (o_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [NB_DATA-1:0] mem [0:(1<<AW)-1];
    int cyc    = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int rd_cyc = 0;
    int wr_cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (o_dmem_enable && o_dmem_write) begin
            mem[o_dmem_addr] <= o_dmem_wdata;
            wr_cnt <= wr_cnt + 1;
            wr_cyc <= cyc;
        end
        if (o_dmem_enable && o_dmem_read) begin
            rd_cnt <= rd_cnt + 1;
            rd_cyc <= cyc;
        end
    end

    always @(negedge clk) begin
        if (o_dmem_enable && o_dmem_read)
            i_dmem_rdata <= mem[o_dmem_addr];
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Observations of the most recent request
    logic        s_en, s_rd, s_wr, s_mis;
    logic [31:0] s_addr;
    int          n_stall, n_valid, n_mis, d_rd, d_wr, rw_gap;
    logic [31:0] got_rdata;

    task automatic req(input logic rd, input logic wr, input logic [1:0] w,
                       input logic uns, input logic [31:0] a, input logic [31:0] d,
                       input logic rel_reset);
        int rd0;
        int wr0;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        @(negedge clk);
        if (rel_reset) i_reset = 1'b1;
        i_valid = 1'b1; i_mem_read = rd; i_mem_write = wr;
        i_width = w; i_unsigned = uns; i_addr = a; i_wdata = d;
        @(posedge clk); #1;
        s_en = o_dmem_enable; s_rd = o_dmem_read; s_wr = o_dmem_write;
        s_addr = 32'(o_dmem_addr); s_mis = o_misaligned;
        // Scramble request fields: the controller must have latched them.
        i_valid = 1'b0; i_mem_read = 1'($urandom); i_mem_write = 1'($urandom);
        i_width = 2'($urandom); i_unsigned = 1'($urandom);
        i_addr = $urandom; i_wdata = $urandom;
        n_stall = 0; n_valid = 0; n_mis = 0; got_rdata = 32'hxxxxxxxx;
        for (int c = 0; c < 6; c++) begin
            if (o_stall) n_stall++;
            if (o_misaligned) n_mis++;
            if (o_rdata_valid) begin
                n_valid++;
                got_rdata = o_rdata;
            end
            @(posedge clk); #1;
        end
        d_rd = rd_cnt - rd0;
        d_wr = wr_cnt - wr0;
        rw_gap = wr_cyc - rd_cyc;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        i_reset = 1'b0; i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
        i_width = 2'b00; i_unsigned = 1'b0; i_addr = '0; i_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_stall",  32'(o_stall), 32'd0);
        check("reset_ctrl",   {29'd0, o_dmem_enable, o_dmem_read, o_dmem_write}, 32'd0);
        check("reset_addr",   32'(o_dmem_addr), 32'd0);
        check("reset_wdata",  o_dmem_wdata, 32'd0);
        check("reset_rdata",  o_rdata, 32'd0);
        check("reset_flags",  {30'd0, o_rdata_valid, o_misaligned}, 32'd0);
        @(negedge clk); i_reset = 1'b1;

        // Word store then word load
        req(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
        check("sw_first_ctrl", {29'd0, s_en, s_rd, s_wr}, 32'b101);
        check("sw_first_addr", s_addr, 32'd4);
        check("sw_stall",      32'(n_stall), 32'd1);
        check("sw_mem4",       mem[4], 32'hDEADBEEF);
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
        check("lw_first_ctrl", {29'd0, s_en, s_rd, s_wr}, 32'b110);
        check("lw_stall",      32'(n_stall), 32'd1);
        check("lw_valid_cnt",  32'(n_valid), 32'd1);
        check("lw_rdata",      got_rdata, 32'hDEADBEEF);
        check("lw_rdata_hold", o_rdata, 32'hDEADBEEF);

        // Byte and half loads from 0x80FF7F01
        req(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF7F01, 1'b0);
        req(1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0);
        check("lb_13",  got_rdata, 32'hFFFFFF80);
        req(1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0);
        check("lbu_13", got_rdata, 32'h00000080);
        req(1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1'b0);
        check("lb_10",  got_rdata, 32'h00000001);
        req(1'b1, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b0);
        check("lbu_11", got_rdata, 32'h0000007F);
        req(1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0);
        check("lh_12",  got_rdata, 32'hFFFF80FF);
        req(1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b0);
        check("lhu_12", got_rdata, 32'h000080FF);

        // Sub-word stores via read-modify-write
        req(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 1'b0);
        req(1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFFABCD, 1'b0);
        check("sh_first_ctrl", {29'd0, s_en, s_rd, s_wr}, 32'b110);
        check("sh_stall",      32'(n_stall), 32'd2);
        check("sh_reads",      32'(d_rd), 32'd1);
        check("sh_writes",     32'(d_wr), 32'd1);
        check("sh_rd_then_wr", 32'(rw_gap), 32'd1);
        check("sh_valid_cnt",  32'(n_valid), 32'd0);
        check("sh_mem4",       mem[4], 32'hABCD3344);
        req(1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'hEEEEEE55, 1'b0);
        check("sb_stall", 32'(n_stall), 32'd2);
        check("sb_mem4",  mem[4], 32'hABCD5544);

        // Misaligned word load
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
        check("mis_pulses", 32'(n_mis), 32'd1);
        check("mis_first",  32'(s_mis), 32'd1);
        check("mis_enable", 32'(s_en), 32'd0);
        check("mis_stall",  32'(n_stall), 32'd0);
        check("mis_access", 32'(d_rd + d_wr), 32'd0);
`else
        check("mis_pulses", 32'(n_mis), 32'd0);
        check("mis_stall",  32'(n_stall), 32'd1);
        check("mis_rdata",  got_rdata, 32'hABCD5544);
`endif

        // Reset at the edge after an SB acceptance
        begin
            int wr0;
            wr0 = wr_cnt;
            @(negedge clk);
            i_valid = 1'b1; i_mem_read = 1'b0; i_mem_write = 1'b1;
            i_width = 2'b00; i_unsigned = 1'b0; i_addr = 32'h10; i_wdata = 32'h99;
            @(posedge clk); #1;
            i_valid = 1'b0; i_reset = 1'b0;
            @(posedge clk); #1;
            check("rst_mid_stall", 32'(o_stall), 32'd0);
            check("rst_mid_ctrl",  {29'd0, o_dmem_enable, o_dmem_read, o_dmem_write}, 32'd0);
            check("rst_mid_addr",  32'(o_dmem_addr), 32'd0);
            check("rst_mid_wdata", o_dmem_wdata, 32'd0);
            check("rst_mid_rdata", o_rdata, 32'd0);
            check("rst_mid_flags", {30'd0, o_rdata_valid, o_misaligned}, 32'd0);
            repeat (2) @(posedge clk);
            #1;
            check("rst_mid_no_write", 32'(wr_cnt - wr0), 32'd0);
            check("rst_mid_mem4",     mem[4], 32'hABCD5544);
        end
        // Request on the first edge after reset is released
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1);
        check("post_rst_valid", 32'(n_valid), 32'd1);
        check("post_rst_rdata", got_rdata, 32'hABCD5544);

        // Simultaneous read and write: write wins
        req(1'b1, 1'b1, 2'b10, 1'b0, 32'h0, 32'h5, 1'b0);
        check("rw_mem0",      mem[0], 32'h5);
        check("rw_valid_cnt", 32'(n_valid), 32'd0);
        check("rw_reads",     32'(d_rd), 32'd0);
        check("rw_stall",     32'(n_stall), 32'd1);

        // Reserved width behaves as a word load
        req(1'b1, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 1'b0);
        check("rsv_width_rdata", got_rdata, 32'h5);

        // Valid without read or write is ignored
        req(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h77, 1'b0);
        check("noop_enable", 32'(s_en), 32'd0);
        check("noop_stall",  32'(n_stall), 32'd0);
        check("noop_access", 32'(d_rd + d_wr), 32'd0);
        check("noop_rdata",  o_rdata, 32'h5);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
